// File: rtl/down_counter_sequencer_pkg.sv
// Shared state encodings and default parameters for the down-counter sequencer.
// The auto-reload option (DOWN_CNT_AUTORELOAD_EN) is selected in the top module.
package down_counter_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/down_counter_sequencer_core.sv
// Synchronous WIDTH-bit down-counter datapath driven by the sequencer.
// Clr and Load take priority over Dec; Dec saturates at zero.
module down_counter_core
    import down_counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Dec,
    output logic [WIDTH-1:0] Count
);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            Count <= '0;
        end else if (Load) begin
            Count <= LoadVal;
        end else if (Dec && (Count != '0)) begin
            Count <= Count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/down_counter_sequencer.sv
// One-shot down-counter timer controller: IDLE -> RUN -> DONE -> IDLE.
// Define DOWN_CNT_AUTORELOAD_EN to let DONE restart from the captured load value.
module down_counter_sequencer
    import down_counter_sequencer_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Start,
    input  logic             Stop,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Reload,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       State
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    state_t           stateReg;
    logic [PW-1:0]    preCnt;
    logic [WIDTH-1:0] loadReg;
    logic             busyReg;
    logic             doneReg;
    logic             tick;
    logic             coreLoad;
    logic             coreDec;
    logic [WIDTH-1:0] coreLoadVal;

    assign tick = (preCnt == PW'(PRESCALE - 1));

    // Datapath strobes decoded from the present state so Count moves on the same edge as the FSM.
    always_comb begin
        coreLoad    = 1'b0;
        coreDec     = 1'b0;
        coreLoadVal = LoadVal;
        if (!Clr && !Stop) begin
            case (stateReg)
                ST_IDLE: coreLoad = Start;
                ST_RUN:  coreDec  = tick;
`ifdef DOWN_CNT_AUTORELOAD_EN
                ST_DONE: begin
                    coreLoad    = Reload;
                    coreLoadVal = loadReg;
                end
`endif
                default: ;
            endcase
        end
    end

    down_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .Clk    (Clk),
        .Clr    (Clr),
        .Load   (coreLoad),
        .LoadVal(coreLoadVal),
        .Dec    (coreDec),
        .Count  (Count)
    );

    // Busy/Done are registered alongside the state so they always reflect the state just entered.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            stateReg <= ST_IDLE;
            preCnt   <= '0;
            loadReg  <= '0;
            busyReg  <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            if (Stop) begin
                stateReg <= ST_IDLE;
                preCnt   <= '0;
            end else begin
                case (stateReg)
                    ST_IDLE: begin
                        if (Start) begin
                            loadReg <= LoadVal;
                            preCnt  <= '0;
                            if (LoadVal != '0) begin
                                stateReg <= ST_RUN;
                                busyReg  <= 1'b1;
                            end else begin
                                stateReg <= ST_DONE;
                                doneReg  <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (tick) begin
                            preCnt <= '0;
                            if (Count == WIDTH'(1)) begin
                                stateReg <= ST_DONE;
                                doneReg  <= 1'b1;
                            end else begin
                                busyReg <= 1'b1;
                            end
                        end else begin
                            preCnt  <= preCnt + PW'(1);
                            busyReg <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        stateReg <= ST_IDLE;
`ifdef DOWN_CNT_AUTORELOAD_EN
                        if (Reload) begin
                            preCnt <= '0;
                            if (loadReg != '0) begin
                                stateReg <= ST_RUN;
                                busyReg  <= 1'b1;
                            end else begin
                                stateReg <= ST_DONE;
                                doneReg  <= 1'b1;
                            end
                        end
`endif
                    end
                    default: stateReg <= ST_IDLE;
                endcase
            end
        end
    end

`ifndef DOWN_CNT_AUTORELOAD_EN
    logic unusedReload;
    assign unusedReload = ^{Reload, loadReg};
`endif

    assign Busy  = busyReg;
    assign Done  = doneReg;
    assign State = stateReg;

endmodule

// File: tb/tb_down_counter_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed post-edge snapshots, a negedge monitor pops and compares.
// dutA runs PRESCALE=1, dutB runs PRESCALE=3; both share clock and Clr.
module tb_down_counter_sequencer;

    typedef struct packed {
        logic [3:0] count;
        logic [1:0] state;
        logic       busy;
        logic       done;
    } snap_t;

    typedef struct {
        snap_t snap;
        int    step;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       startA, stopA, reloadA, startB, stopB, reloadB;
    logic [3:0] loadValA, loadValB;
    logic [3:0] countA, countB;
    logic       busyA, doneA, busyB, doneB;
    logic [1:0] stateA, stateB;

    exp_t expA[$];
    exp_t expB[$];
    int   checks   = 0;
    int   failures = 0;
    int   stepNum  = 0;

    always #5 clk = ~clk;

    down_counter_sequencer #(.WIDTH(4), .PRESCALE(1)) dutA (
        .Clk(clk), .Clr(clr), .Start(startA), .Stop(stopA), .LoadVal(loadValA),
        .Reload(reloadA), .Count(countA), .Busy(busyA), .Done(doneA), .State(stateA)
    );

    down_counter_sequencer #(.WIDTH(4), .PRESCALE(3)) dutB (
        .Clk(clk), .Clr(clr), .Start(startB), .Stop(stopB), .LoadVal(loadValB),
        .Reload(reloadB), .Count(countB), .Busy(busyB), .Done(doneB), .State(stateB)
    );

    function automatic snap_t mk(input int c, input int s);
        snap_t r;
        r.count = 4'(c);
        r.state = 2'(s);
        r.busy  = (s == 1);
        r.done  = (s == 2);
        return r;
    endfunction

    // sel: 0 = dutA, 1 = dutB, 2 = both (reset only); the unselected DUT sees idle inputs.
    task automatic applyStimulus(input int sel, input logic c, input logic st, input logic sp,
                                 input int lv, input logic rl, input int expCount, input int expState);
        exp_t e;
        clr      = c;
        startA   = (sel != 1) ? st : 1'b0;
        stopA    = (sel != 1) ? sp : 1'b0;
        reloadA  = (sel != 1) ? rl : 1'b0;
        loadValA = (sel != 1) ? 4'(lv) : 4'd0;
        startB   = (sel != 0) ? st : 1'b0;
        stopB    = (sel != 0) ? sp : 1'b0;
        reloadB  = (sel != 0) ? rl : 1'b0;
        loadValB = (sel != 0) ? 4'(lv) : 4'd0;
        @(posedge clk);
        stepNum++;
        e.snap = mk(expCount, expState);
        e.step = stepNum;
        if (sel != 1) expA.push_back(e);
        if (sel != 0) expB.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input string name, input exp_t e, input snap_t act);
        checks++;
        if (act !== e.snap) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got count=%0d state=%0d busy=%0b done=%0b, expected count=%0d state=%0d busy=%0b done=%0b",
                     name, e.step, act.count, act.state, act.busy, act.done,
                     e.snap.count, e.snap.state, e.snap.busy, e.snap.done);
        end
    endtask

    always @(negedge clk) begin
        if (expA.size() > 0) checkOutput("dutA", expA.pop_front(), {countA, stateA, busyA, doneA});
        if (expB.size() > 0) checkOutput("dutB", expB.pop_front(), {countB, stateB, busyB, doneB});
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with Start asserted on both DUTs
        applyStimulus(2, 1, 1, 0, 5, 0, 0, 0);
        applyStimulus(2, 1, 1, 0, 5, 0, 0, 0);

        // One-shot countdown from 5
        applyStimulus(0, 0, 1, 0, 5, 0, 5, 1);
        for (int i = 4; i >= 1; i--) applyStimulus(0, 0, 0, 0, 0, 0, i, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Zero load goes straight to DONE
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Abort at Count==6 freezes the count
        applyStimulus(0, 0, 1, 0, 9, 0, 9, 1);
        for (int i = 8; i >= 6; i--) applyStimulus(0, 0, 0, 0, 0, 0, i, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 6, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);

        // Start and Stop together in IDLE: nothing captured
        applyStimulus(0, 0, 1, 1, 3, 0, 6, 0);
        applyStimulus(0, 0, 0, 0, 3, 0, 6, 0);

        // Stop while in DONE
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);

        // Start held through RUN and DONE is ignored until back in IDLE
        applyStimulus(0, 0, 1, 0, 2, 0, 2, 1);
        applyStimulus(0, 0, 1, 0, 7, 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 7, 0, 0, 2);
        applyStimulus(0, 0, 1, 0, 7, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 7, 0, 7, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 7, 0);

        // Smallest non-zero load
        applyStimulus(0, 0, 1, 0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Clr mid-run overrides everything
        applyStimulus(0, 0, 1, 0, 4, 0, 4, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 1);
        applyStimulus(0, 1, 1, 0, 8, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reload held through a 3-count run
        applyStimulus(0, 0, 1, 0, 3, 1, 3, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 2);
`ifdef DOWN_CNT_AUTORELOAD_EN
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 2, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`else
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
`endif

        // PRESCALE=3: each value held three cycles, DONE six edges after Start
        applyStimulus(1, 0, 1, 0, 2, 0, 2, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 2, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 2, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        // PRESCALE=3 with Clr mid-prescale, then a fresh single-count run
        applyStimulus(1, 0, 1, 0, 4, 0, 4, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 4, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 3, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 1, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if ((expA.size() + expB.size()) != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d entries left in scoreboard, expected 0", expA.size() + expB.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
